inv_mixcolumns_iter: RTL and testbench



---
 rtl/inv_mixcolumns_iter_if.sv | 21 ++
 rtl/inv_mixcolumns_iter.sv | 120 ++++++++++++
 tb/tb_inv_mixcolumns_iter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_mixcolumns_iter_if.sv
// Stream interface for the iterative InvMixColumns unit: input state handshake,
// output state handshake and a busy indicator.
interface inv_mixcolumns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: one shared column multiplier walks columns 0..3
// of the held state, then the result is offered on the output handshake.
module inv_mixcolumns_iter (
  input  logic                  clk,
  input  logic                  rst,
  inv_mixcolumns_iter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   fsm_r;
  logic [1:0]   cnt_r;
  logic [127:0] state_r;
  logic [31:0]  col_sel_s;
  logic [31:0]  col_res_s;
  logic [127:0] state_next_s;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31 - 8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Select the column addressed by cnt; column 0 lives in the top word.
  always_comb begin
    col_sel_s = 32'h0000_0000;
    case (cnt_r)
      2'd0:    col_sel_s = state_r[127:96];
      2'd1:    col_sel_s = state_r[95:64];
      2'd2:    col_sel_s = state_r[63:32];
      2'd3:    col_sel_s = state_r[31:0];
      default: col_sel_s = 32'h0000_0000;
    endcase
  end

  assign col_res_s = inv_col(col_sel_s);

  // Write the transformed column back into its own slot.
  always_comb begin
    state_next_s = state_r;
    case (cnt_r)
      2'd0:    state_next_s[127:96] = col_res_s;
      2'd1:    state_next_s[95:64]  = col_res_s;
      2'd2:    state_next_s[63:32]  = col_res_s;
      2'd3:    state_next_s[31:0]   = col_res_s;
      default: state_next_s = state_r;
    endcase
  end

  // Control FSM, column counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= IDLE;
      cnt_r   <= 2'd0;
      state_r <= 128'd0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.in_valid) begin
            state_r <= bus.data;
            cnt_r   <= 2'd0;
            fsm_r   <= RUN;
          end
        end
        RUN: begin
          state_r <= state_next_s;
          cnt_r   <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            fsm_r <= DONE;
          end
        end
        DONE: begin
          // A stalled consumer freezes the result regardless of new input.
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              state_r <= bus.data;
              cnt_r   <= 2'd0;
              fsm_r   <= RUN;
            end else begin
              fsm_r <= IDLE;
            end
          end
        end
        default: begin
          fsm_r <= IDLE;
          cnt_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (fsm_r == IDLE) || ((fsm_r == DONE) && bus.out_ready);
  assign bus.out_valid = (fsm_r == DONE);
  assign bus.busy      = (fsm_r == RUN);
  assign bus.out       = state_r;

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Directed and randomised checks of inv_mixcolumns_iter against hand-computed
// vectors and an independent forward-MixColumns round trip.
module tb_inv_mixcolumns_iter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  inv_mixcolumns_iter_if bus ();

  inv_mixcolumns_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fxt(input logic [7:0] b);
    fxt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns, used only to build round-trip stimulus.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = fxt(a0) ^ fxt(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ fxt(a1) ^ fxt(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ fxt(a2) ^ fxt(a3) ^ a3;
      r[103 - 32*c -: 8] = fxt(a0) ^ a0 ^ a1 ^ a2 ^ fxt(a3);
    end
    fwd_mix = r;
  endfunction

  function automatic logic [127:0] rnd128();
    rnd128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one block from IDLE through to a single output transfer.
  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
    bus.data     = din;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready_idle"}, 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data     = rnd128();
    #1;
    chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
    chk({tag, "_in_ready_run"}, 128'(bus.in_ready), 128'd0);
    chk({tag, "_valid_t0"}, 128'(bus.out_valid), 128'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk({tag, "_valid_lat"}, 128'(bus.out_valid), 128'(k == 4));
    end
    chk({tag, "_out"}, bus.out, exp);
    chk({tag, "_busy_done"}, 128'(bus.busy), 128'd0);
    chk({tag, "_in_ready_stall"}, 128'(bus.in_ready), 128'd0);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready_pass"}, 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk({tag, "_valid_after"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_in_ready_after"}, 128'(bus.in_ready), 128'd1);
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_00000000;
  localparam int           NRAND  = 400;

  initial begin
    logic [127:0] vec [8];
    logic [127:0] q [$];
    logic [127:0] cur_x;
    logic [127:0] prev_out;
    logic         prev_hold;
    logic         seen;
    int           in_idx;
    int           out_idx;
    int           last_acc;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data      = 128'd0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_out", bus.out, 128'd0);

    // Known vectors with latency checks.
    @(negedge clk);
    run_one("fips", V1_IN, V1_OUT);
    @(negedge clk);
    run_one("order", V2_IN, V2_OUT);

    // Reset mid-RUN discards the block.
    @(negedge clk);
    bus.data     = V1_IN;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mrst_busy", 128'(bus.busy), 128'd0);
    chk("mrst_out", bus.out, 128'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mrst_no_valid", 128'(seen), 128'd0);

    // Backpressure: result held while the consumer stalls.
    @(negedge clk);
    bus.data     = V1_IN;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.data     = rnd128();
      #1;
      chk("bp_out", bus.out, V1_OUT);
      chk("bp_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_single_transfer", 128'(seen), 128'd0);
    bus.out_ready = 1'b0;

    // Back-to-back: 8 queued states, both handshakes held high.
    vec[0] = V1_OUT;
    vec[1] = V2_OUT;
    for (int i = 2; i < 8; i++) vec[i] = rnd128();
    @(negedge clk);
    in_idx        = 0;
    out_idx       = 0;
    last_acc      = 0;
    bus.data      = fwd_mix(vec[0]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("b2b_out", bus.out, vec[out_idx]);
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (in_idx > 0) chk("b2b_spacing", 128'(cyc - last_acc), 128'd5);
        last_acc = cyc;
        in_idx++;
      end
      @(negedge clk);
      if (in_idx < 8) bus.data = fwd_mix(vec[in_idx]);
      else bus.in_valid = 1'b0;
    end
    chk("b2b_count", 128'(out_idx), 128'd8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised round trip with stalls on both sides.
    in_idx    = 0;
    out_idx   = 0;
    prev_hold = 1'b0;
    prev_out  = 128'd0;
    cur_x     = rnd128();
    for (int cyc = 0; cyc < 20000 && out_idx < NRAND; cyc++) begin
      bus.in_valid  = (in_idx < NRAND) && ($urandom_range(0, 3) != 0);
      bus.data      = bus.in_valid ? fwd_mix(cur_x) : rnd128();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_hold) begin
        chk("rt_hold_out", bus.out, prev_out);
        chk("rt_hold_valid", 128'(bus.out_valid), 128'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rt_nonempty", 128'(q.size() != 0), 128'd1);
        if (q.size() != 0) chk("rt_out", bus.out, q.pop_front());
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_x);
        cur_x = rnd128();
        in_idx++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_out  = bus.out;
      @(negedge clk);
    end
    chk("rt_count", 128'(out_idx), 128'(NRAND));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
